mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage sequencer sitting directly upstream of the data cache.
- Accepts one load/store request at a time from the execute stage and translates byte/halfword/word accesses into cache accesses; the cache interface is big-endian, reads 4 bytes from the address, and writes either a full word or the byte at address+3.
- Performs read-modify-write for halfword stores.
- Returns zero-extended load data with a destination tag to writeback.

Parameters:
- TAG_W, 4, width of destination-register tag carried with a request.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request this cycle
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-justified
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00=byte, 01=halfword, 10=word; 11 treated as word
- req_tag_i  in  TAG_W  destination tag
- dc_address_o  out  32  cache address
- dc_data_o  out  32  cache write data
- dc_we_o  out  1  cache write enable
- dc_sel_o  out  2  01=byte write, 11=word write
- dc_data_i  in  32  cache read data
- dc_stall_i  in  1  cache busy; hold all dc_* outputs
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_data_o  out  32  zero-extended load data; 0 for stores
- rsp_tag_o  out  TAG_W  tag of the completing request
- rsp_err_o  out  1  misaligned access (feature only; otherwise 0)

Behaviour:
- Reset: state=IDLE; req_ready_o=1; rsp_valid_o=0; rsp_data_o=0; rsp_tag_o=0; rsp_err_o=0; dc_we_o=0; dc_address_o=0; dc_data_o=0; dc_sel_o=11.
- Acceptance: on the edge where req_valid_i && req_ready_o, latch addr/wdata/we/size/tag. req_ready_o=1 only in IDLE.
- States and transitions from IDLE on acceptance:
  - load → LOAD
  - byte store → STORE_B
  - word store → STORE_W
  - halfword store → RMW_RD
- LOAD:
  - Drive dc_address_o=A, dc_we_o=0.
  - On the first edge with dc_stall_i=0, capture: word=dc_data_i; half={16'b0,dc_data_i[31:16]}; byte={24'b0,dc_data_i[31:24]}.
  - → DONE.
- STORE_B:
  - Drive dc_address_o=A−3 (mod 2^32), dc_data_o={24'b0,wdata[7:0]}, dc_sel_o=01, dc_we_o=1.
  - Commit on the first edge with dc_stall_i=0 → DONE.
- STORE_W:
  - Drive dc_address_o=A, dc_data_o=wdata, dc_sel_o=11, dc_we_o=1.
  - Commit on the first edge with dc_stall_i=0 → DONE.
- RMW_RD:
  - Read at A.
  - On the first non-stalled edge, latch merge={wdata[15:0],dc_data_i[15:0]}.
  - → RMW_WR.
- RMW_WR:
  - Write merge at A with sel=11, dc_we_o=1.
  - Commit on the first non-stalled edge → DONE.
- DONE:
  - rsp_valid_o=1 for exactly one cycle, with rsp_tag_o and rsp_data_o.
  - → IDLE; no new request is accepted in DONE.
- dc_we_o is 0 in every state other than STORE_B, STORE_W and RMW_WR.
- Stall: while dc_stall_i=1, state and all dc_* outputs are held; no capture and no commit.
- Latency without stall (accept edge = cycle 0):
  - load/byte/word: rsp_valid_o high in cycle 2.
  - halfword store: rsp_valid_o high in cycle 3.
  - Each stalled cycle adds 1.
- Address arithmetic is 32-bit wrap: a byte store at A<3 wraps to 0xFFFFFFFD+A.
- req_size_i=11 is treated as word.
- Reset mid-operation: synchronous reset wins over any pending commit; the state returns to IDLE and no response is issued for the aborted request.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - Halfword with A[0]=1, or word with A[1:0]≠00, goes IDLE→DONE directly.
  - No cache access (dc_we_o stays 0).
  - rsp_err_o=1 and rsp_data_o=0 in DONE.
  - Response in cycle 1.
- Undefined:
  - Misaligned accesses proceed as aligned ones; rsp_err_o is tied 0.

Test Plan:
- Word store then load: store A=0x100, wdata=0xDEADBEEF; then load word A=0x100 → dc_we_o 1 for one cycle at address 0x100, sel 11; load rsp_data_o=0xDEADBEEF in cycle 2; rsp_tag echoes.
- Byte store then loads: byte store A=0x101, wdata=0x000000AA → dc_address_o=0x0FE, sel 01; then load byte at 0x101 → 0x000000AA; load word at 0x100 → 0xDEAABEEF.
- Halfword RMW: after word 0xDEADBEEF at 0x100, halfword store 0x1234 at 0x100 → read then write 0x1234BEEF; rsp in cycle 3; halfword load returns 0x00001234.
- Stall: dc_stall_i high for 3 cycles during STORE_W → dc_* held constant, single commit, rsp_valid_o in cycle 5, req_ready_o low until IDLE.
- Reset mid-op: assert rst_i in RMW_WR → no write, no rsp_valid_o, req_ready_o=1 the cycle after reset deasserts.
- MEM_ALIGN_CHECK_EN: word load at 0x102 → rsp_err_o=1, rsp_data_o=0, dc_we_o never high, rsp in cycle 1; without the macro the same load completes in cycle 2 with rsp_err_o=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store sequencer in front of a big-endian data cache
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned halfword/word accesses complete with rsp_err_o).
module mem_access_unit #(
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    input  logic             req_we_i,
    input  logic [1:0]       req_size_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [31:0]      dc_address_o,
    output logic [31:0]      dc_data_o,
    output logic             dc_we_o,
    output logic [1:0]       dc_sel_o,
    input  logic [31:0]      dc_data_i,
    input  logic             dc_stall_i,
    output logic             rsp_valid_o,
    output logic [31:0]      rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE_B,
        S_STORE_W,
        S_RMW_RD,
        S_RMW_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SEL_B  = 2'b01;
    localparam logic [1:0] SEL_W  = 2'b11;

    state_t             state_q, state_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [1:0]         size_q, size_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        dc_addr_q, dc_addr_d;
    logic [31:0]        dc_data_q, dc_data_d;
    logic               dc_we_q, dc_we_d;
    logic [1:0]         dc_sel_q, dc_sel_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               accept;
    logic               misalign;

    assign req_ready_o = (state_q == S_IDLE);
    assign accept      = req_valid_i && req_ready_o;

`ifdef MEM_ALIGN_CHECK_EN
    // Sizes 10 and 11 are both words, so size[1] selects the word alignment rule.
    assign misalign = ((req_size_i == SIZE_H) && req_addr_i[0]) ||
                      (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        tag_d      = tag_q;
        dc_addr_d  = dc_addr_q;
        dc_data_d  = dc_data_q;
        dc_we_d    = dc_we_q;
        dc_sel_d   = dc_sel_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wdata_d    = req_wdata_i[15:0];
                    size_d     = req_size_i;
                    tag_d      = req_tag_i;
                    rsp_data_d = 32'd0;
                    rsp_err_d  = 1'b0;
                    if (misalign) begin
                        rsp_err_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (!req_we_i) begin
                        dc_addr_d = req_addr_i;
                        dc_we_d   = 1'b0;
                        dc_sel_d  = SEL_W;
                        state_d   = S_LOAD;
                    end else if (req_size_i == SIZE_B) begin
                        // The cache writes the byte at address+3, so aim three bytes low.
                        dc_addr_d = req_addr_i - 32'd3;
                        dc_data_d = {24'd0, req_wdata_i[7:0]};
                        dc_we_d   = 1'b1;
                        dc_sel_d  = SEL_B;
                        state_d   = S_STORE_B;
                    end else if (req_size_i == SIZE_H) begin
                        dc_addr_d = req_addr_i;
                        dc_we_d   = 1'b0;
                        dc_sel_d  = SEL_W;
                        state_d   = S_RMW_RD;
                    end else begin
                        dc_addr_d = req_addr_i;
                        dc_data_d = req_wdata_i;
                        dc_we_d   = 1'b1;
                        dc_sel_d  = SEL_W;
                        state_d   = S_STORE_W;
                    end
                end
            end
            S_LOAD: begin
                if (!dc_stall_i) begin
                    if (size_q == SIZE_B) begin
                        rsp_data_d = {24'd0, dc_data_i[31:24]};
                    end else if (size_q == SIZE_H) begin
                        rsp_data_d = {16'd0, dc_data_i[31:16]};
                    end else begin
                        rsp_data_d = dc_data_i;
                    end
                    state_d = S_DONE;
                end
            end
            S_RMW_RD: begin
                if (!dc_stall_i) begin
                    // New halfword lands in the big-endian upper half at A.
                    dc_data_d = {wdata_q, dc_data_i[15:0]};
                    dc_we_d   = 1'b1;
                    dc_sel_d  = SEL_W;
                    state_d   = S_RMW_WR;
                end
            end
            S_STORE_B, S_STORE_W, S_RMW_WR: begin
                if (!dc_stall_i) begin
                    dc_we_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wdata_q    <= 16'd0;
            size_q     <= 2'b00;
            tag_q      <= '0;
            dc_addr_q  <= 32'd0;
            dc_data_q  <= 32'd0;
            dc_we_q    <= 1'b0;
            dc_sel_q   <= SEL_W;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            tag_q      <= tag_d;
            dc_addr_q  <= dc_addr_d;
            dc_data_q  <= dc_data_d;
            dc_we_q    <= dc_we_d;
            dc_sel_q   <= dc_sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Reset must beat a commit already presented to the cache on the same edge.
    assign dc_we_o      = dc_we_q & ~rst_i;
    assign dc_address_o = dc_addr_q;
    assign dc_data_o    = dc_data_q;
    assign dc_sel_o     = dc_sel_q;

    assign rsp_valid_o  = (state_q == S_DONE);
    assign rsp_data_o   = rsp_data_q;
    assign rsp_tag_o    = tag_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a big-endian cache model
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [3:0]  req_tag = 4'd0;
    logic [31:0] dc_address;
    logic [31:0] dc_wdata;
    logic        dc_we;
    logic [1:0]  dc_sel;
    logic [31:0] dc_rdata;
    logic        dc_stall = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_err;

    int n_cmp = 0;
    int n_fail = 0;
    int we_cycles = 0;
    int commits = 0;

    logic [7:0] mem [0:511] = '{default: 8'h00};
    logic [8:0] ra;

    mem_access_unit #(.TAG_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_we_i     (req_we),
        .req_size_i   (req_size),
        .req_tag_i    (req_tag),
        .dc_address_o (dc_address),
        .dc_data_o    (dc_wdata),
        .dc_we_o      (dc_we),
        .dc_sel_o     (dc_sel),
        .dc_data_i    (dc_rdata),
        .dc_stall_i   (dc_stall),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .rsp_tag_o    (rsp_tag),
        .rsp_err_o    (rsp_err)
    );

    always #5 clk = ~clk;

    // Big-endian cache: reads 4 bytes at the address, writes a word or the byte at address+3.
    assign ra = dc_address[8:0];
    assign dc_rdata = {mem[ra], mem[ra + 9'd1], mem[ra + 9'd2], mem[ra + 9'd3]};

    always @(posedge clk) begin
        if (dc_we) begin
            we_cycles <= we_cycles + 1;
            if (!dc_stall) begin
                commits <= commits + 1;
                if (dc_sel == 2'b01) begin
                    mem[ra + 9'd3] <= dc_wdata[7:0];
                end else begin
                    mem[ra]        <= dc_wdata[31:24];
                    mem[ra + 9'd1] <= dc_wdata[23:16];
                    mem[ra + 9'd2] <= dc_wdata[15:8];
                    mem[ra + 9'd3] <= dc_wdata[7:0];
                end
            end
        end
    end

    int          lat;
    logic [31:0] rd;
    logic [3:0]  rt;
    logic        re;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [1:0]  s_sel;
    logic        s_we;
    int          we0;
    int          cm0;

    // Issues one request; lat is the cycle of rsp_valid_o counted from the accept edge (0 = no response).
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [1:0] sz, input logic [3:0] tg);
        @(negedge clk);
        req_addr  = a;
        req_wdata = wd;
        req_we    = we;
        req_size  = sz;
        req_tag   = tg;
        req_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        rd = 32'hx;
        rt = 4'hx;
        re = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_valid = 1'b0;
                s_addr = dc_address;
                s_data = dc_wdata;
                s_sel  = dc_sel;
                s_we   = dc_we;
            end
            if (rsp_valid) begin
                lat = i;
                rd = rsp_data;
                rt = rsp_tag;
                re = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        n_cmp++; if (rsp_tag !== 4'd0) begin n_fail++; $display("FAIL reset_rsp_tag got %h want 0", rsp_tag); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        n_cmp++; if (dc_we !== 1'b0) begin n_fail++; $display("FAIL reset_dc_we got %b want 0", dc_we); end
        n_cmp++; if (dc_address !== 32'd0) begin n_fail++; $display("FAIL reset_dc_address got %h want 0", dc_address); end
        n_cmp++; if (dc_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_dc_data got %h want 0", dc_wdata); end
        n_cmp++; if (dc_sel !== 2'b11) begin n_fail++; $display("FAIL reset_dc_sel got %b want 11", dc_sel); end
    endtask

    task automatic test_word_store_load;
        we0 = we_cycles;
        issue(32'h100, 32'hDEADBEEF, 1'b1, 2'b10, 4'd3);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", lat); end
        n_cmp++; if ({s_addr, s_data, s_sel, s_we} !== {32'h100, 32'hDEADBEEF, 2'b11, 1'b1}) begin
            n_fail++; $display("FAIL sw_dc got %h/%h/%b/%b want 100/deadbeef/11/1", s_addr, s_data, s_sel, s_we); end
        n_cmp++; if (we_cycles - we0 !== 1) begin n_fail++; $display("FAIL sw_we_cycles got %0d want 1", we_cycles - we0); end
        n_cmp++; if ({rd, rt} !== {32'd0, 4'd3}) begin n_fail++; $display("FAIL sw_rsp got %h/%h want 0/3", rd, rt); end
        issue(32'h100, 32'd0, 1'b0, 2'b10, 4'd5);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", lat); end
        n_cmp++; if ({rd, rt, re} !== {32'hDEADBEEF, 4'd5, 1'b0}) begin
            n_fail++; $display("FAIL lw_rsp got %h/%h/%b want deadbeef/5/0", rd, rt, re); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL done_ready got %b want 0", req_ready); end
    endtask

    task automatic test_byte_store;
        issue(32'h101, 32'h000000AA, 1'b1, 2'b00, 4'd1);
        n_cmp++; if ({s_addr, s_data, s_sel, s_we} !== {32'h0FE, 32'h000000AA, 2'b01, 1'b1}) begin
            n_fail++; $display("FAIL sb_dc got %h/%h/%b/%b want 0fe/000000aa/01/1", s_addr, s_data, s_sel, s_we); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL sb_latency got %0d want 2", lat); end
        issue(32'h101, 32'd0, 1'b0, 2'b00, 4'd2);
        n_cmp++; if (rd !== 32'h000000AA) begin n_fail++; $display("FAIL lb_data got %h want 000000aa", rd); end
        issue(32'h100, 32'd0, 1'b0, 2'b10, 4'd4);
        n_cmp++; if (rd !== 32'hDEAABEEF) begin n_fail++; $display("FAIL lw_after_sb got %h want deaabeef", rd); end
        issue(32'h1, 32'h12345655, 1'b1, 2'b00, 4'd6);
        n_cmp++; if ({s_addr, s_data} !== {32'hFFFFFFFE, 32'h00000055}) begin
            n_fail++; $display("FAIL sb_wrap got %h/%h want fffffffe/00000055", s_addr, s_data); end
        issue(32'h0, 32'd0, 1'b0, 2'b01, 4'd7);
        n_cmp++; if (rd !== 32'h00000055) begin n_fail++; $display("FAIL lh_wrap got %h want 00000055", rd); end
    endtask

    task automatic test_halfword_rmw;
        issue(32'h100, 32'hDEADBEEF, 1'b1, 2'b10, 4'd0);
        cm0 = commits;
        issue(32'h100, 32'hFFFF1234, 1'b1, 2'b01, 4'd7);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sh_latency got %0d want 3", lat); end
        n_cmp++; if ({s_addr, s_we} !== {32'h100, 1'b0}) begin n_fail++; $display("FAIL sh_read got %h/%b want 100/0", s_addr, s_we); end
        n_cmp++; if (commits - cm0 !== 1) begin n_fail++; $display("FAIL sh_commits got %0d want 1", commits - cm0); end
        n_cmp++; if ({rd, rt} !== {32'd0, 4'd7}) begin n_fail++; $display("FAIL sh_rsp got %h/%h want 0/7", rd, rt); end
        issue(32'h100, 32'd0, 1'b0, 2'b10, 4'd8);
        n_cmp++; if (rd !== 32'h1234BEEF) begin n_fail++; $display("FAIL sh_merged got %h want 1234beef", rd); end
        issue(32'h100, 32'd0, 1'b0, 2'b01, 4'd9);
        n_cmp++; if (rd !== 32'h00001234) begin n_fail++; $display("FAIL lh_data got %h want 00001234", rd); end
    endtask

    task automatic test_stall;
        logic [66:0] snap;
        cm0 = commits;
        @(negedge clk);
        req_addr = 32'h10C; req_wdata = 32'h0BADF00D; req_we = 1'b1; req_size = 2'b10; req_tag = 4'd9;
        req_valid = 1'b1;
        @(posedge clk);
        snap = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                dc_stall = 1'b1;
                snap = {dc_address, dc_wdata, dc_sel, dc_we};
            end else if (c <= 4) begin
                n_cmp++; if ({dc_address, dc_wdata, dc_sel, dc_we} !== snap) begin
                    n_fail++; $display("FAIL stall_hold c%0d got %h want %h", c, {dc_address, dc_wdata, dc_sel, dc_we}, snap); end
            end
            if (c <= 4) begin
                n_cmp++; if ({req_ready, rsp_valid} !== 2'b00) begin
                    n_fail++; $display("FAIL stall_ready_rsp c%0d got %b want 00", c, {req_ready, rsp_valid}); end
            end
            if (c == 4) dc_stall = 1'b0;
            if (c == 5) begin
                n_cmp++; if ({rsp_valid, rsp_tag} !== {1'b1, 4'd9}) begin
                    n_fail++; $display("FAIL stall_rsp got %b/%h want 1/9", rsp_valid, rsp_tag); end
            end
        end
        n_cmp++; if (snap !== {32'h10C, 32'h0BADF00D, 2'b11, 1'b1}) begin
            n_fail++; $display("FAIL stall_dc got %h want 10c/0badf00d/11/1", snap); end
        n_cmp++; if (commits - cm0 !== 1) begin n_fail++; $display("FAIL stall_commits got %0d want 1", commits - cm0); end
        issue(32'h10C, 32'd0, 1'b0, 2'b10, 4'd1);
        n_cmp++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL stall_readback got %h want 0badf00d", rd); end
    endtask

    task automatic test_reset_mid_op;
        cm0 = commits;
        @(negedge clk);
        req_addr = 32'h100; req_wdata = 32'h00005678; req_we = 1'b1; req_size = 2'b01; req_tag = 4'd3;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (dc_we !== 1'b1) begin n_fail++; $display("FAIL rmw_wr_we got %b want 1", dc_we); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL abort_state got %b want 10", {req_ready, rsp_valid}); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rsp got %b want 0", rsp_valid); end
        n_cmp++; if (commits - cm0 !== 0) begin n_fail++; $display("FAIL abort_commits got %0d want 0", commits - cm0); end
        issue(32'h100, 32'd0, 1'b0, 2'b10, 4'd2);
        n_cmp++; if (rd !== 32'h1234BEEF) begin n_fail++; $display("FAIL abort_mem got %h want 1234beef", rd); end
    endtask

    task automatic test_misaligned;
        we0 = we_cycles;
        issue(32'h102, 32'd0, 1'b0, 2'b10, 4'hA);
`ifdef MEM_ALIGN_CHECK_EN
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL mis_latency got %0d want 1", lat); end
        n_cmp++; if ({rd, rt, re} !== {32'd0, 4'hA, 1'b1}) begin
            n_fail++; $display("FAIL mis_rsp got %h/%h/%b want 0/a/1", rd, rt, re); end
`else
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL mis_latency got %0d want 2", lat); end
        n_cmp++; if ({rd, rt, re} !== {32'hBEEF0000, 4'hA, 1'b0}) begin
            n_fail++; $display("FAIL mis_rsp got %h/%h/%b want beef0000/a/0", rd, rt, re); end
`endif
        n_cmp++; if (we_cycles - we0 !== 0) begin n_fail++; $display("FAIL mis_we got %0d want 0", we_cycles - we0); end
    endtask

    task automatic test_back_to_back;
        issue(32'h108, 32'hCAFEF00D, 1'b1, 2'b11, 4'hC);
        n_cmp++; if ({lat, s_sel, s_we} !== {32'd2, 2'b11, 1'b1}) begin
            n_fail++; $display("FAIL size11_store got %0d/%b/%b want 2/11/1", lat, s_sel, s_we); end
        issue(32'h108, 32'd0, 1'b0, 2'b11, 4'hD);
        n_cmp++; if ({rd, rt} !== {32'hCAFEF00D, 4'hD}) begin
            n_fail++; $display("FAIL size11_load got %h/%h want cafef00d/d", rd, rt); end
        issue(32'h10A, 32'd0, 1'b0, 2'b00, 4'hE);
        n_cmp++; if ({lat, rd} !== {32'd2, 32'h000000F0}) begin
            n_fail++; $display("FAIL lb_b2b got %0d/%h want 2/000000f0", lat, rd); end
    endtask

    initial begin
        test_reset;
        test_word_store_load;
        test_byte_store;
        test_halfword_rmw;
        test_stall;
        test_reset_mid_op;
        test_misaligned;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
